// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Same-cycle lookup for fetch, resolution-driven training, registered flush/redirect and profiling counters.
module branch_predictor_btb #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic              res_is_branch,
  input  logic              res_is_jump,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] res_pred_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] kind_q, kind_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];

  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;
  logic [PERF_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [1:0]       unused_fetch_lsb;

  assign f_idx            = fetch_pc[IDX_W+1:2];
  assign f_tag            = fetch_pc[ADDR_W-1:IDX_W+2];
  assign unused_fetch_lsb = fetch_pc[1:0];

  assign pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = pred_hit && (kind_q[f_idx] || cnt_q[f_idx][1]);
  assign pred_target = pred_taken ? target_q[f_idx] : '0;

  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              r_hit;
  logic              accept;
  logic              is_ctrl;
  logic              actual_taken;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] actual_next;
  logic [ADDR_W-1:0] pred_next;
  logic              mispredict;

  assign r_idx        = res_pc[IDX_W+1:2];
  assign r_tag        = res_pc[ADDR_W-1:IDX_W+2];
  assign r_hit        = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  // Anything resolving while a flush is in flight is on the wrong path.
  assign accept       = res_valid && !flush_q;
  assign is_ctrl      = res_is_branch || res_is_jump;
  assign actual_taken = res_is_jump || (res_is_branch && res_taken);
  assign pc_plus4     = res_pc + ADDR_W'(4);
  assign actual_next  = actual_taken ? res_target : pc_plus4;
  assign pred_next    = res_pred_taken ? res_pred_target : pc_plus4;
  assign mispredict   = (actual_next != pred_next);

  always_comb begin
    valid_d  = valid_q;
    kind_d   = kind_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (accept) begin
      if (is_ctrl && r_hit) begin
        if (res_is_jump) begin
          cnt_d[r_idx] = 2'b11;
        end else if (res_taken) begin
          if (cnt_q[r_idx] != 2'b11) cnt_d[r_idx] = cnt_q[r_idx] + 2'd1;
        end else begin
          if (cnt_q[r_idx] != 2'b00) cnt_d[r_idx] = cnt_q[r_idx] - 2'd1;
        end
        if (actual_taken) target_d[r_idx] = res_target;
      end else if (is_ctrl && actual_taken) begin
        valid_d[r_idx]  = 1'b1;
        tag_d[r_idx]    = r_tag;
        target_d[r_idx] = res_target;
        kind_d[r_idx]   = res_is_jump;
        cnt_d[r_idx]    = res_is_jump ? 2'b11 : 2'b10;
      end else if (!is_ctrl && r_hit) begin
        // A non-control instruction matched: the entry is a stale alias.
        valid_d[r_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    flush_d       = accept && mispredict;
    redirect_d    = (accept && mispredict) ? actual_next : '0;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (perf_clr) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (accept) begin
      if (is_ctrl && !(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + PERF_W'(1);
      if (mispredict && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Payload fields are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    kind_q   <= kind_d;
    tag_q    <= tag_d;
    target_q <= target_d;
    cnt_q    <= cnt_d;
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed scenarios plus randomized traffic
// checked against an array-based model of the predictor table and counters.
module tb_branch_predictor_btb;
  localparam int AW = 32;
  localparam int NE = 16;
  localparam int PW = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] fetch_pc = '0;
  logic          pred_hit, pred_taken;
  logic [AW-1:0] pred_target;
  logic          res_valid = 1'b0;
  logic [AW-1:0] res_pc = '0;
  logic          res_is_branch = 1'b0, res_is_jump = 1'b0, res_taken = 1'b0;
  logic [AW-1:0] res_target = '0;
  logic          res_pred_taken = 1'b0;
  logic [AW-1:0] res_pred_target = '0;
  logic          flush;
  logic [AW-1:0] redirect_pc;
  logic          perf_clr = 1'b0;
  logic [PW-1:0] branch_cnt, mispred_cnt;

  branch_predictor_btb #(.ADDR_W(AW), .ENTRIES(NE), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_is_branch(res_is_branch),
    .res_is_jump(res_is_jump), .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .flush(flush), .redirect_pc(redirect_pc), .perf_clr(perf_clr),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model
  bit          m_valid [NE];
  bit          m_kind  [NE];
  logic [31:0] m_tag   [NE];
  logic [31:0] m_target[NE];
  int          m_cnt   [NE];
  int          m_bcnt, m_mcnt;
  bit          m_flush;
  logic [31:0] m_redirect;

  // Lookup expected/observed, captured mid-cycle before the edge
  bit          e_hit, e_taken;
  logic [31:0] e_target;
  logic        o_hit, o_taken;
  logic [31:0] o_target;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / (4 * NE);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_valid[i] = 0;
    m_bcnt = 0; m_mcnt = 0; m_flush = 0; m_redirect = '0;
  endtask

  task automatic apply(input logic r, input logic [31:0] fpc, input logic rv,
                       input logic [31:0] pc, input logic isb, input logic isj,
                       input logic tk, input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt, input logic clr);
    int i;
    bit acc, ctrl, at, hit;
    logic [31:0] an, pn;
    rst = r; fetch_pc = fpc; res_valid = rv; res_pc = pc; res_is_branch = isb;
    res_is_jump = isj; res_taken = tk; res_target = tgt; res_pred_taken = ptk;
    res_pred_target = ptgt; perf_clr = clr;
    #1;
    i = idx_of(fpc);
    e_hit    = m_valid[i] && (m_tag[i] == tag_of(fpc));
    e_taken  = e_hit && (m_kind[i] || m_cnt[i] >= 2);
    e_target = e_taken ? m_target[i] : 32'h0;
    o_hit = pred_hit; o_taken = pred_taken; o_target = pred_target;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      acc = rv && !m_flush;
      m_flush = 0; m_redirect = '0;
      if (acc) begin
        ctrl = isb || isj;
        at   = isj || (isb && tk);
        an   = at ? tgt : pc + 32'd4;
        pn   = ptk ? ptgt : pc + 32'd4;
        if (an != pn) begin
          m_flush = 1; m_redirect = an;
          m_mcnt = (m_mcnt < PMAX) ? m_mcnt + 1 : PMAX;
        end
        if (ctrl) m_bcnt = (m_bcnt < PMAX) ? m_bcnt + 1 : PMAX;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (ctrl && hit) begin
          if (isj) m_cnt[i] = 3;
          else if (tk) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
          if (at) m_target[i] = tgt;
        end else if (ctrl && at) begin
          m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt;
          m_kind[i] = isj; m_cnt[i] = isj ? 3 : 2;
        end else if (!ctrl && hit) begin
          m_valid[i] = 0;
        end
      end
      if (clr) begin m_bcnt = 0; m_mcnt = 0; end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] fpc);
    apply(0, fpc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %0b want 0", flush); end
    tests_run++; if (redirect_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_redirect: got %h want 0", redirect_pc); end
    tests_run++; if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0) begin tests_failed++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
    idle(32'h100);
    tests_run++; if (o_hit !== 1'b0 || o_taken !== 1'b0 || o_target !== 32'h0) begin tests_failed++;
      $display("FAIL reset_lookup: got hit=%0b taken=%0b tgt=%h want 0/0/0", o_hit, o_taken, o_target); end
  endtask

  task automatic test_train();
    apply(0, 32'h0, 1, 32'h100, 1, 0, 1, 32'h200, 0, 32'h0, 0);
    tests_run++; if (flush !== 1'b1 || redirect_pc !== 32'h200) begin tests_failed++;
      $display("FAIL train_alloc_flush: got flush=%0b pc=%h want 1/00000200", flush, redirect_pc); end
    idle(32'h100);
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL train_flush_pulse: got %0b want 0", flush); end
    tests_run++; if (o_hit !== 1'b1 || o_taken !== 1'b1 || o_target !== 32'h200) begin tests_failed++;
      $display("FAIL train_lookup: got hit=%0b taken=%0b tgt=%h want 1/1/00000200", o_hit, o_taken, o_target); end
    tests_run++; if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin tests_failed++;
      $display("FAIL train_counts: got %0d/%0d want 1/1", branch_cnt, mispred_cnt); end
    apply(0, 32'h0, 1, 32'h100, 1, 0, 0, 32'h200, 1, 32'h200, 0);
    tests_run++; if (flush !== 1'b1 || redirect_pc !== 32'h104) begin tests_failed++;
      $display("FAIL train_nt_flush: got flush=%0b pc=%h want 1/00000104", flush, redirect_pc); end
    idle(32'h100);
    tests_run++; if (o_hit !== 1'b1 || o_taken !== 1'b0) begin tests_failed++;
      $display("FAIL train_weak_nt: got hit=%0b taken=%0b want 1/0", o_hit, o_taken); end
    apply(0, 32'h0, 1, 32'h100, 1, 0, 0, 32'h200, 0, 32'h0, 0);
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL train_correct_noflush: got %0b want 0", flush); end
    // From strong-NT one taken outcome must still predict not-taken
    apply(0, 32'h0, 1, 32'h100, 1, 0, 1, 32'h200, 0, 32'h0, 0);
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL train_sat_flush: got %0b want 1", flush); end
    idle(32'h100);
    tests_run++; if (o_taken !== 1'b0 || o_target !== 32'h0) begin tests_failed++;
      $display("FAIL train_strong_nt: got taken=%0b tgt=%h want 0/0", o_taken, o_target); end
    tests_run++; if (branch_cnt !== 4'd4 || mispred_cnt !== 4'd3) begin tests_failed++;
      $display("FAIL train_counts2: got %0d/%0d want 4/3", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_wrong_path();
    apply(0, 32'h0, 1, 32'h180, 1, 0, 1, 32'h300, 0, 32'h0, 0);
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL wp_flush: got %0b want 1", flush); end
    apply(0, 32'h0, 1, 32'h1c0, 0, 1, 0, 32'h400, 0, 32'h0, 0);
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL wp_no_second_flush: got %0b want 0", flush); end
    tests_run++; if (branch_cnt !== 4'd5 || mispred_cnt !== 4'd4) begin tests_failed++;
      $display("FAIL wp_counts: got %0d/%0d want 5/4", branch_cnt, mispred_cnt); end
    idle(32'h1c0);
    tests_run++; if (o_hit !== 1'b0) begin tests_failed++; $display("FAIL wp_no_alloc: got hit=%0b want 0", o_hit); end
  endtask

  task automatic test_alias();
    apply(0, 32'h0, 1, 32'h40, 0, 1, 0, 32'h900, 0, 32'h0, 0);
    idle(32'h40);
    tests_run++; if (o_hit !== 1'b1 || o_taken !== 1'b1 || o_target !== 32'h900) begin tests_failed++;
      $display("FAIL alias_jump_alloc: got hit=%0b taken=%0b tgt=%h want 1/1/00000900", o_hit, o_taken, o_target); end
    apply(0, 32'h0, 1, 32'h440, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL alias_nonctrl_flush: got %0b want 0", flush); end
    idle(32'h40);
    tests_run++; if (o_hit !== 1'b1) begin tests_failed++; $display("FAIL alias_keep: got hit=%0b want 1", o_hit); end
    apply(0, 32'h0, 1, 32'h440, 0, 1, 0, 32'h800, 0, 32'h0, 0);
    tests_run++; if (flush !== 1'b1 || redirect_pc !== 32'h800) begin tests_failed++;
      $display("FAIL alias_replace_flush: got flush=%0b pc=%h want 1/00000800", flush, redirect_pc); end
    idle(32'h40);
    tests_run++; if (o_hit !== 1'b0) begin tests_failed++; $display("FAIL alias_old_miss: got hit=%0b want 0", o_hit); end
    idle(32'h440);
    tests_run++; if (o_hit !== 1'b1 || o_target !== 32'h800) begin tests_failed++;
      $display("FAIL alias_new_hit: got hit=%0b tgt=%h want 1/00000800", o_hit, o_target); end
    apply(0, 32'h0, 1, 32'h440, 0, 0, 0, 32'h0, 1, 32'h800, 0);
    tests_run++; if (flush !== 1'b1 || redirect_pc !== 32'h444) begin tests_failed++;
      $display("FAIL alias_invalidate_flush: got flush=%0b pc=%h want 1/00000444", flush, redirect_pc); end
    idle(32'h0);
    idle(32'h440);
    tests_run++; if (o_hit !== 1'b0) begin tests_failed++; $display("FAIL alias_invalidated: got hit=%0b want 0", o_hit); end
  endtask

  task automatic test_reset_during_flush();
    apply(0, 32'h0, 1, 32'h2c0, 0, 1, 0, 32'h500, 0, 32'h0, 0);
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL rstflush_pre: got %0b want 1", flush); end
    apply(1, 32'h2c0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tests_run++; if (o_hit !== 1'b1) begin tests_failed++; $display("FAIL rstflush_prehit: got hit=%0b want 1", o_hit); end
    tests_run++; if (flush !== 1'b0 || branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin tests_failed++;
      $display("FAIL rstflush_post: got flush=%0b cnt=%0d/%0d want 0/0/0", flush, branch_cnt, mispred_cnt); end
    idle(32'h2c0);
    tests_run++; if (o_hit !== 1'b0) begin tests_failed++; $display("FAIL rstflush_table: got hit=%0b want 0", o_hit); end
  endtask

  task automatic test_saturation();
    apply(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 17; k++) begin
      apply(0, 32'h0, 1, 32'h3000 + 32'(k * 4), 0, 0, 0, 32'h0, 1, 32'h0, 0);
      idle(32'h0);
    end
    tests_run++; if (mispred_cnt !== 4'hF) begin tests_failed++; $display("FAIL sat_hold: got %h want f", mispred_cnt); end
    tests_run++; if (branch_cnt !== 4'h0) begin tests_failed++; $display("FAIL sat_branch_cnt: got %h want 0", branch_cnt); end
    apply(0, 32'h0, 1, 32'h3000, 0, 1, 0, 32'h3400, 0, 32'h0, 1);
    tests_run++; if (mispred_cnt !== 4'h0 || branch_cnt !== 4'h0) begin tests_failed++;
      $display("FAIL sat_clr_priority: got %h/%h want 0/0", branch_cnt, mispred_cnt); end
    tests_run++; if (flush !== 1'b1 || redirect_pc !== 32'h3400) begin tests_failed++;
      $display("FAIL sat_clr_flush: got flush=%0b pc=%h want 1/00003400", flush, redirect_pc); end
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic [31:0] pc, tgt, ptgt;
    int kind;
    for (int n = 0; n < 600; n++) begin
      pc   = rand_pc();
      tgt  = rand_pc() & 32'hFFFF_FFFC;
      ptgt = ($urandom_range(0, 1) == 0) ? tgt : (rand_pc() & 32'hFFFF_FFFC);
      kind = $urandom_range(0, 3);
      apply(($urandom_range(0, 63) == 0), rand_pc(), ($urandom_range(0, 1) == 1), pc,
            (kind >= 2), (kind == 1), 1'($urandom_range(0, 1)), tgt,
            1'($urandom_range(0, 1)), ptgt, ($urandom_range(0, 31) == 0));
      tests_run++; if (o_hit !== e_hit || o_taken !== e_taken || o_target !== e_target) begin tests_failed++;
        $display("FAIL rand_lookup[%0d]: got %0b/%0b/%h want %0b/%0b/%h", n, o_hit, o_taken, o_target, e_hit, e_taken, e_target); end
      tests_run++; if (flush !== m_flush) begin tests_failed++;
        $display("FAIL rand_flush[%0d]: got %0b want %0b", n, flush, m_flush); end
      if (m_flush) begin
        tests_run++; if (redirect_pc !== m_redirect) begin tests_failed++;
          $display("FAIL rand_redirect[%0d]: got %h want %h", n, redirect_pc, m_redirect); end
      end
      tests_run++; if (int'(branch_cnt) != m_bcnt || int'(mispred_cnt) != m_mcnt) begin tests_failed++;
        $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", n, branch_cnt, mispred_cnt, m_bcnt, m_mcnt); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_train();
    test_wrong_path();
    test_alias();
    test_reset_during_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
